// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: request size codes,
// bit positions inside the align_load / align_store one-hots, and the
// MA-stage FSM state type.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // align_load one-hot: {lw, lb, lbu, lh, lhu, lwl, lwr}
  localparam int LD_LW  = 6;
  localparam int LD_LB  = 5;
  localparam int LD_LBU = 4;
  localparam int LD_LH  = 3;
  localparam int LD_LHU = 2;
  localparam int LD_LWL = 1;
  localparam int LD_LWR = 0;

  // align_store one-hot: {sw, sb, sh, swl, swr}
  localparam int SD_SW  = 4;
  localparam int SD_SB  = 3;
  localparam int SD_SH  = 2;
  localparam int SD_SWL = 1;
  localparam int SD_SWR = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SENT = 2'd2
  } ma_state_t;

endpackage

// File: rtl/mem_req_if.sv
// Address-phase request bus between the MA stage and the memory interlayer.
interface mem_req_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;

  modport master (output req, wr, size, addr, wstrb, wdata, input addr_ok);
  modport slave  (input req, wr, size, addr, wstrb, wdata, output addr_ok);
endinterface

// File: rtl/store_lane_gen.sv
// Store lane generator: maps a store kind, the low address bits and the
// source register onto byte strobes, lane-shifted write data and the
// request size. Purely combinational so the uncached path can reuse it.
module store_lane_gen
  import mips_mem_pkg::*;
(
  input  logic [4:0]  align_store,
  input  logic [1:0]  a,
  input  logic [31:0] b,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [1:0]  size
);

  // Decode store kind into strobes/data; swl/swr fill the low/high lanes.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    size  = SIZE_WORD;
    if (align_store[SD_SW]) begin
      wstrb = 4'b1111;
      wdata = b;
    end else if (align_store[SD_SH]) begin
      size  = SIZE_HALF;
      wstrb = a[1] ? 4'b1100 : 4'b0011;
      wdata = {b[15:0], b[15:0]};
    end else if (align_store[SD_SB]) begin
      size  = SIZE_BYTE;
      wstrb = 4'b0001 << a;
      wdata = {4{b[7:0]}};
    end else if (align_store[SD_SWL]) begin
      case (a)
        2'd0:    begin wstrb = 4'b0001; wdata = {24'h0, b[31:24]}; end
        2'd1:    begin wstrb = 4'b0011; wdata = {16'h0, b[31:16]}; end
        2'd2:    begin wstrb = 4'b0111; wdata = {8'h0, b[31:8]};   end
        default: begin wstrb = 4'b1111; wdata = b;                 end
      endcase
    end else if (align_store[SD_SWR]) begin
      case (a)
        2'd0:    begin wstrb = 4'b1111; wdata = b;                 end
        2'd1:    begin wstrb = 4'b1110; wdata = {b[23:0], 8'h0};   end
        2'd2:    begin wstrb = 4'b1100; wdata = {b[15:0], 16'h0};  end
        default: begin wstrb = 4'b1000; wdata = {b[7:0], 24'h0};   end
      endcase
    end
  end

endmodule

// File: rtl/mem_req.sv
// MA-stage request generator: captures one instruction from EX, issues a
// single address-phase request for loads/stores, holds it until addr_ok,
// then hands the instruction to WB.
// Optional feature macro: MEM_REQ_ADDR_CHECK_EN (misaligned lw/lh/lhu/sw/sh
// issue no request and raise adel/ades instead).
module mem_req
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_p,
  input  logic        EX_ready,
  output logic        MA_enable,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] rf_B_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [6:0]  align_load_in,
  input  logic [4:0]  align_store_in,
  input  logic [31:0] EX_PC,
  input  logic        WB_enable,
  output logic        MA_ready,
  output logic [31:0] MA_PC,
  mem_req_if.master   bus,
  output logic        adel,
  output logic        ades
);

  ma_state_t   state, state_nxt;
  logic        valid;
  logic        comming, leaving;
  logic        ld_mis_in, st_mis_in;
  logic        mem_op_in;

  logic [31:0] alu_res_p0;
  logic [31:0] rf_b_p0;
  logic        mem_read_p0;
  logic        mem_write_p0;
  logic [6:0]  align_load_p0;
  logic [4:0]  align_store_p0;

  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [1:0]  st_size;
  logic [1:0]  ld_size;
  logic        word_align;

`ifdef MEM_REQ_ADDR_CHECK_EN
  logic adel_p0, ades_p0;

  assign ld_mis_in = mem_read_in &&
                     ((align_load_in[LD_LW] && (alu_res_in[1:0] != 2'd0)) ||
                      ((align_load_in[LD_LH] || align_load_in[LD_LHU]) && alu_res_in[0]));
  assign st_mis_in = mem_write_in &&
                     ((align_store_in[SD_SW] && (alu_res_in[1:0] != 2'd0)) ||
                      (align_store_in[SD_SH] && alu_res_in[0]));

  // Address-error flags travel with the instruction; outputs gated by valid.
  always_ff @(posedge clk) begin
    if (comming) begin
      adel_p0 <= ld_mis_in;
      ades_p0 <= st_mis_in;
    end
  end

  assign adel = valid && adel_p0;
  assign ades = valid && ades_p0;
`else
  assign ld_mis_in = 1'b0;
  assign st_mis_in = 1'b0;
  assign adel      = 1'b0;
  assign ades      = 1'b0;
`endif

  assign mem_op_in = (mem_read_in || mem_write_in) && !ld_mis_in && !st_mis_in;

  // Next state, handshake and request strobe.
  always_comb begin
    state_nxt = state;
    bus.req   = (state == S_REQ);
    MA_ready  = valid && ((state == S_SENT) || ((state == S_REQ) && bus.addr_ok));
    leaving   = MA_ready && WB_enable;
    MA_enable = !valid || leaving;
    comming   = MA_enable && EX_ready;
    if (comming) begin
      state_nxt = mem_op_in ? S_REQ : S_SENT;
    end else begin
      case (state)
        S_REQ:   if (bus.addr_ok) state_nxt = S_SENT;
        S_SENT:  if (leaving)     state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control state: FSM and valid bit.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state <= S_IDLE;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (comming)      valid <= 1'b1;
      else if (leaving) valid <= 1'b0;
    end
  end

  // ---- stage p0: instruction fields captured on comming ----
  always_ff @(posedge clk) begin
    if (comming) begin
      alu_res_p0     <= alu_res_in;
      rf_b_p0        <= rf_B_in;
      mem_read_p0    <= mem_read_in;
      mem_write_p0   <= mem_write_in;
      align_load_p0  <= align_load_in;
      align_store_p0 <= align_store_in;
      MA_PC          <= EX_PC;
    end
  end

  store_lane_gen u_lane (
    .align_store (align_store_p0),
    .a           (alu_res_p0[1:0]),
    .b           (rf_b_p0),
    .wstrb       (st_wstrb),
    .wdata       (st_wdata),
    .size        (st_size)
  );

  // Load request size from the load kind.
  always_comb begin
    ld_size = SIZE_WORD;
    if (align_load_p0[LD_LW] || align_load_p0[LD_LWL] || align_load_p0[LD_LWR])
      ld_size = SIZE_WORD;
    else if (align_load_p0[LD_LH] || align_load_p0[LD_LHU])
      ld_size = SIZE_HALF;
    else if (align_load_p0[LD_LB] || align_load_p0[LD_LBU])
      ld_size = SIZE_BYTE;
  end

  // Unaligned-word ops address the containing word; lanes pick the bytes.
  assign word_align = (mem_read_p0  && (align_load_p0[LD_LWL]  || align_load_p0[LD_LWR])) ||
                      (mem_write_p0 && (align_store_p0[SD_SWL] || align_store_p0[SD_SWR]));

  assign bus.wr    = mem_write_p0;
  assign bus.size  = mem_write_p0 ? st_size : ld_size;
  assign bus.addr  = word_align ? {alu_res_p0[31:2], 2'b00} : alu_res_p0;
  assign bus.wstrb = mem_write_p0 ? st_wstrb : 4'b0000;
  assign bus.wdata = st_wdata;

endmodule
